// File: rtl/apb_master_if.sv
// APB bus between apb_master and one slave: master drives address/control/write data,
// slave returns read data and ready.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PWRITE;
  logic              PSELx;
  logic              PENABLE;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSELx, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSELx, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: takes a valid/ready command, runs SETUP/ACCESS on the bus
// and returns a one-cycle response pulse, aborting with an error if the slave stalls too long.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_write,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  apb_master_if.master      apb
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;

  assign req_ready   = (state_q == IDLE);
  assign apb.PSELx   = (state_q != IDLE);
  assign apb.PENABLE = (state_q == ACCESS);
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PWRITE  = pwrite_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_error   = rsp_error_q;

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over the timeout on the same edge
        if (apb.PREADY) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : apb.PRDATA;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (reset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

endmodule
